// File: rtl/tnew_scoreboard.sv
// tnew_scoreboard: tracks in-flight GPR writes behind decode as {valid, addr, tnew}
// records, ages them as the pipeline advances, and resolves decode rs/rt against
// them to produce the decode stall and one-hot forwarding selects.
// Optional feature macro: SCOREBOARD_PERF_EN adds the stall_cnt performance counter.
module tnew_scoreboard #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned TNEW_W     = 3,
    parameter int unsigned STALL_CODE = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [4:0]        issue_addr,
    input  logic [TNEW_W-1:0] issue_tnew,
    input  logic              adv,
    input  logic [DEPTH-1:0]  flush,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [TNEW_W-1:0] rs_tuse,
    input  logic [TNEW_W-1:0] rt_tuse,
    output logic              stall,
    output logic              rs_fwd_hit,
    output logic [DEPTH-1:0]  rs_fwd_sel,
    output logic              rt_fwd_hit,
    output logic [DEPTH-1:0]  rt_fwd_sel
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [TNEW_W-1:0] W_STALL_CODE = TNEW_W'(STALL_CODE);

    // Entry 0 is EX, entry DEPTH-1 is the oldest tracked stage.
    logic              r_valid [DEPTH];
    logic [4:0]        r_addr  [DEPTH];
    logic [TNEW_W-1:0] r_tnew  [DEPTH];

    logic              w_rs_match;
    logic [DEPTH-1:0]  w_rs_sel;
    logic [TNEW_W-1:0] w_rs_tnew;
    logic              w_rt_match;
    logic [DEPTH-1:0]  w_rt_sel;
    logic [TNEW_W-1:0] w_rt_tnew;
    logic              w_stall;

    // Aging of a record moving one stage older; STALL_CODE only resolves on entering the last stage.
    function automatic logic [TNEW_W-1:0] f_age(input logic [TNEW_W-1:0] tnew, input logic last);
        if (tnew == W_STALL_CODE)
            f_age = last ? '0 : W_STALL_CODE;
        else if (tnew == '0)
            f_age = '0;
        else
            f_age = tnew - 1'b1;
    endfunction

    // Youngest-match lookup for rs and rt; older matches are shadowed by the first hit found.
    always_comb begin
        w_rs_match = 1'b0;
        w_rs_sel   = '0;
        w_rs_tnew  = '0;
        w_rt_match = 1'b0;
        w_rt_sel   = '0;
        w_rt_tnew  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!w_rs_match && r_valid[k] && (r_addr[k] == rs_addr) && (rs_addr != 5'd0)) begin
                w_rs_match  = 1'b1;
                w_rs_sel[k] = 1'b1;
                w_rs_tnew   = r_tnew[k];
            end
            if (!w_rt_match && r_valid[k] && (r_addr[k] == rt_addr) && (rt_addr != 5'd0)) begin
                w_rt_match  = 1'b1;
                w_rt_sel[k] = 1'b1;
                w_rt_tnew   = r_tnew[k];
            end
        end
    end

    // Decode stall and forwarding selects, combinational from the current entries.
    always_comb begin
        w_stall    = issue_valid & ((w_rs_match & (w_rs_tnew > rs_tuse)) |
                                    (w_rt_match & (w_rt_tnew > rt_tuse)));
        stall      = w_stall;
        rs_fwd_hit = w_rs_match & (w_rs_tnew == '0);
        rt_fwd_hit = w_rt_match & (w_rt_tnew == '0);
        rs_fwd_sel = rs_fwd_hit ? w_rs_sel : '0;
        rt_fwd_sel = rt_fwd_hit ? w_rt_sel : '0;
    end

    // Entry shift/capture on adv, in-place hold otherwise; flush overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_valid[k] <= 1'b0;
                r_addr[k]  <= '0;
                r_tnew[k]  <= '0;
            end
        end else if (adv) begin
            r_valid[0] <= issue_valid & ~w_stall & (issue_addr != 5'd0) & ~flush[0];
            r_addr[0]  <= issue_addr;
            r_tnew[0]  <= issue_tnew;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1] & ~flush[k];
                r_addr[k]  <= r_addr[k-1];
                r_tnew[k]  <= f_age(r_tnew[k-1], k == DEPTH - 1);
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++)
                r_valid[k] <= r_valid[k] & ~flush[k];
        end
    end

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] r_stall_cnt;

    // Count every edge that sees an active stall; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
